// File: rtl/mult_job_ctrl.sv
// Job controller feeding an approximate multiplier from an operand-pair FIFO.
// Define MULT_JOB_TIMEOUT_EN to compile in the WAIT-state watchdog.
module mult_job_ctrl #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic        mult_start,
    output logic [15:0] mult_a,
    output logic [15:0] mult_b,
    input  logic        mult_done,
    input  logic [15:0] mult_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic        out_timeout,
    output logic        busy,
    output logic [4:0]  fifo_count
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0
        || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("mult_job_ctrl: unsupported FIFO_DEPTH or TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t        state;
    logic [15:0]   mem_a [FIFO_DEPTH];
    logic [15:0]   mem_b [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign in_ready = (fifo_count < 5'(FIFO_DEPTH));
    assign push     = in_valid && in_ready;
    // The head leaves the FIFO on the edge that moves IDLE into ISSUE.
    assign pop      = (state == IDLE) && (fifo_count != 5'd0) && !out_valid;
    assign busy     = (state != IDLE);

    // NOTE: the storage array carries no reset; pointers and count define validity,
    // and leaving it unreset keeps it mappable onto plain RAM/regfile cells.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
        end
    end

`ifdef MULT_JOB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wd_cnt;
    logic          wd_expired;
    assign wd_expired = (wd_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign out_timeout = 1'b0;
`endif

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= 5'd0;
            mult_start <= 1'b0;
            mult_a     <= 16'd0;
            mult_b     <= 16'd0;
            out_valid  <= 1'b0;
            out_result <= 16'd0;
`ifdef MULT_JOB_TIMEOUT_EN
            out_timeout <= 1'b0;
            wd_cnt      <= '0;
`endif
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            fifo_count <= fifo_count + {4'd0, push} - {4'd0, pop};

            mult_start <= 1'b0;
            if (out_valid && out_ready) out_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (pop) begin
                        mult_a     <= mem_a[rd_ptr];
                        mult_b     <= mem_b[rd_ptr];
                        mult_start <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef MULT_JOB_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    // A Done on the expiry cycle still wins over the watchdog.
                    if (mult_done) begin
                        out_result <= mult_result;
                        out_valid  <= 1'b1;
`ifdef MULT_JOB_TIMEOUT_EN
                        out_timeout <= 1'b0;
`endif
                        state <= IDLE;
                    end
`ifdef MULT_JOB_TIMEOUT_EN
                    else if (wd_expired) begin
                        out_result  <= 16'hFFFF;
                        out_valid   <= 1'b1;
                        out_timeout <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + TW'(1);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_job_ctrl.sv
// Scoreboard bench for mult_job_ctrl with a 5-cycle multiplier stub.
// Build with MULT_JOB_TIMEOUT_EN to also exercise the watchdog.
module tb_mult_job_ctrl;

    localparam int DEPTH   = 4;
    localparam int TO_CYC  = 16;
    localparam logic [15:0] HANG_A = 16'hDEAD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        mult_start;
    logic [15:0] mult_a;
    logic [15:0] mult_b;
    logic        mult_done;
    logic [15:0] mult_result;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_result;
    logic        out_timeout;
    logic        busy;
    logic [4:0]  fifo_count;

    mult_job_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
        .mult_done(mult_done), .mult_result(mult_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_timeout(out_timeout),
        .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier stub: Done pulses five edges after Start is sampled; a == HANG_A never completes.
    int          stub_cnt = 0;
    logic        stub_done = 1'b0;
    logic [15:0] stub_res = '0;
    always @(posedge clk) begin
        stub_done <= 1'b0;
        if (mult_start) begin
            stub_cnt <= (mult_a == HANG_A) ? 0 : 5;
            stub_res <= 16'((32'(mult_a) * 32'(mult_b)) >> 8);
        end else if (stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) stub_done <= 1'b1;
        end
    end
    assign mult_done   = stub_done;
    assign mult_result = stub_res;

    typedef struct {
        logic [15:0] res;
        logic        to;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
`ifdef MULT_JOB_TIMEOUT_EN
        if (a == HANG_A) begin
            e.res = 16'hFFFF;
            e.to  = 1'b1;
            return e;
        end
`endif
        e.res = 16'((32'(a) * 32'(b)) >> 8);
        e.to  = 1'b0;
        return e;
    endfunction

    // Input side of the scoreboard: every accepted pair queues its expected result.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) exp_q.delete();
            else if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b));
        end
    end

    // Output monitor: compares on handshake, checks hold-stability, latency and Start shape.
    int          start_cnt = 0;
    int          last_start_cyc = 0;
    logic        prev_start = 1'b0;
    logic        prev_ov = 1'b0;
    logic        prev_hs = 1'b0;
    logic [15:0] held_res = '0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_ov = 1'b0;
                prev_hs = 1'b0;
                prev_start = 1'b0;
            end else begin
                if (mult_start) begin
                    check("start_single_cycle", {31'd0, prev_start}, 32'd0);
                    check("start_while_result_pending", {31'd0, out_valid}, 32'd0);
                    start_cnt++;
                    last_start_cyc = cyc;
                end
                prev_start = mult_start;
                if (out_valid) begin
                    if (!prev_ov || prev_hs) begin
                        check("issue_to_result_latency", 32'(cyc - last_start_cyc),
                              out_timeout ? 32'(TO_CYC + 1) : 32'd7);
                    end else begin
                        check("out_result_held", {16'd0, out_result}, {16'd0, held_res});
                    end
                    held_res = out_result;
                    if (out_ready) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_result", {16'd0, out_result}, 32'hFFFF_FFFF);
                        end else begin
                            e = exp_q.pop_front();
                            check("out_result", {16'd0, out_result}, {16'd0, e.res});
                            check("out_timeout", {31'd0, out_timeout}, {31'd0, e.to});
                        end
                    end
                end
                prev_ov = out_valid;
                prev_hs = out_valid && out_ready;
            end
        end
    end

    task automatic push(input logic [15:0] a, input logic [15:0] b);
        bit ok = 1'b0;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) check("push_accept_bound", 32'd0, 32'd1);
    endtask

    task automatic wait_out_valid(input int max_cyc);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        if (!seen) check("out_valid_bound", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input int max_cyc);
        out_ready = 1'b1;
        for (int i = 0; i < max_cyc && (exp_q.size() != 0 || busy || out_valid); i++)
            wait_cycles(1);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    endtask

    bit rand_on;
    int sc;

    initial begin
        // Reset with in_valid asserted: nothing may be accepted.
        rst = 1'b1;
        in_valid = 1'b1;
        in_a = 16'h1234;
        in_b = 16'h5678;
        wait_cycles(3);
        rst = 1'b0;
        in_valid = 1'b0;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_mult_start", {31'd0, mult_start}, 32'd0);
        check("rst_mult_a", {16'd0, mult_a}, 32'd0);
        check("rst_mult_b", {16'd0, mult_b}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_result", {16'd0, out_result}, 32'd0);
        check("rst_out_timeout", {31'd0, out_timeout}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_fifo_count", {27'd0, fifo_count}, 32'd0);

        // Single job: 0x2000 * 0x0040 >> 8 = 0x0800 with a single Start pulse.
        out_ready = 1'b1;
        sc = start_cnt;
        push(16'h2000, 16'h0040);
        wait_out_valid(50);
        check("single_result_value", {16'd0, held_res}, 32'h0800);
        wait_cycles(3);
        check("single_start_pulses", 32'(start_cnt - sc), 32'd1);

        // Backpressure: result held 20 cycles, queued job must not start.
        out_ready = 1'b0;
        push(16'h0100, 16'h0300);
        push(16'h0200, 16'h0200);
        wait_out_valid(50);
        sc = start_cnt;
        wait_cycles(20);
        check("bp_no_new_start", 32'(start_cnt - sc), 32'd0);
        check("bp_out_valid_held", {31'd0, out_valid}, 32'd1);
        check("bp_idle", {31'd0, busy}, 32'd0);
        drain(200);

        // FIFO full: a held result blocks issue, four pushes fill the FIFO.
        out_ready = 1'b0;
        push(16'h00FF, 16'h0101);
        wait_out_valid(50);
        for (int i = 0; i < DEPTH; i++) push(16'(16'h0110 * (i + 1)), 16'(16'h0033 + i));
        check("full_fifo_count", {27'd0, fifo_count}, 32'(DEPTH));
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        fork
            push(16'hABCD, 16'h0102);
            begin wait_cycles(3); out_ready = 1'b1; end
        join
        drain(400);

        // Reset in WAIT with two pairs queued: everything abandoned.
        out_ready = 1'b1;
        push(16'h1111, 16'h2222);
        push(16'h3333, 16'h4444);
        push(16'h5555, 16'h6666);
        wait_cycles(2);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        check("pre_rst_fifo_count", {27'd0, fifo_count}, 32'd2);
        rst = 1'b1;
        in_valid = 1'b1;
        in_a = 16'h7777;
        in_b = 16'h8888;
        wait_cycles(1);
        rst = 1'b0;
        in_valid = 1'b0;
        check("mid_rst_fifo_count", {27'd0, fifo_count}, 32'd0);
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        sc = start_cnt;
        wait_cycles(12);
        check("post_rst_no_result", {31'd0, out_valid}, 32'd0);
        check("post_rst_no_start", 32'(start_cnt - sc), 32'd0);

`ifdef MULT_JOB_TIMEOUT_EN
        // Watchdog: hung job reports 0xFFFF with timeout, the next job is normal.
        out_ready = 1'b1;
        push(HANG_A, 16'h0010);
        push(16'h0400, 16'h0400);
        drain(200);
`endif

        // Randomized traffic with random downstream backpressure.
        rand_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    logic [15:0] ra;
                    ra = 16'($urandom);
                    if (ra == HANG_A) ra = 16'h0001;
                    repeat ($urandom_range(0, 3)) wait_cycles(1);
                    push(ra, 16'($urandom));
                end
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    out_ready = 1'($urandom_range(0, 1));
                    wait_cycles(1);
                end
            end
        join
        drain(1000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: got cycle %0d expected completion", cyc);
        $fatal(1, "time limit");
    end

endmodule
